// File: rtl/poly_pipe_horner.sv
// Horner-form polynomial pipeline y = a0 + a1*x + ... + aN*x^N, one multiply-add per stage.
// Optional build macro POLY_PIPE_SAT_EN: clamp overflowing sums to all-ones, sticky to the output.
module poly_pipe_horner #(
    parameter int WIDTHIN  = 16,
    parameter int FRAC_IN  = 14,
    parameter int WIDTHOUT = 32,
    parameter int FRAC_OUT = 25,
    parameter int ORDER    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [WIDTHIN-1:0]  i_x,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [WIDTHOUT-1:0] o_y,
    input  logic                coef_we,
    input  logic [3:0]          coef_addr,
    input  logic [WIDTHOUT-1:0] coef_wdata,
    output logic                coef_err
);
    localparam int PW = WIDTHOUT + WIDTHIN;

    typedef logic [WIDTHOUT-1:0] word_t;
    typedef logic [WIDTHIN-1:0]  x_t;

    // round(2^FRAC_OUT / k!), evaluated at elaboration for the reset coefficients
    function automatic word_t default_coef(input int k);
        logic [63:0] fact;
        logic [63:0] q;
        fact = 64'd1;
        for (int i = 2; i <= k; i++) fact = fact * 64'(i);
        q = ((64'd1 << FRAC_OUT) + (fact >> 1)) / fact;
        return word_t'(q);
    endfunction

    word_t          coef    [0:ORDER];
    word_t          acc     [0:ORDER];
    x_t             xs      [0:ORDER-1];
    word_t          nxt_acc [1:ORDER];
    logic [ORDER:0] vld;
    logic           en;
    logic           coef_ok;

    // The whole pipe moves as one: it stalls only when a result is stuck at the output
    assign en      = i_ready | ~vld[ORDER];
    assign o_ready = en;
    assign o_valid = vld[ORDER];
    assign coef_ok = coef_we & ~(|vld) & ~i_valid & (coef_addr <= 4'(ORDER));

`ifdef POLY_PIPE_SAT_EN
    logic [ORDER:0]    sat;
    logic [ORDER:1]    nxt_sat;
    logic [PW-1:0]     shifted;
    logic [WIDTHOUT:0] sum;

    assign o_y = sat[ORDER] ? '1 : acc[ORDER];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        nxt_acc = '{default: '0};
        nxt_sat = '0;
        shifted = '0;
        sum     = '0;
        for (int j = 1; j <= ORDER; j++) begin
            shifted    = (PW'(acc[j-1]) * PW'(xs[j-1])) >> FRAC_IN;
            sum        = {1'b0, shifted[WIDTHOUT-1:0]} + {1'b0, coef[ORDER-j]};
            nxt_sat[j] = sat[j-1] | sum[WIDTHOUT] | (|shifted[PW-1:WIDTHOUT]);
            nxt_acc[j] = nxt_sat[j] ? '1 : sum[WIDTHOUT-1:0];
        end
    end
`else
    assign o_y = acc[ORDER];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        nxt_acc = '{default: '0};
        for (int j = 1; j <= ORDER; j++) begin
            nxt_acc[j] = word_t'((PW'(acc[j-1]) * PW'(xs[j-1])) >> FRAC_IN) + coef[ORDER-j];
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld      <= '0;
            coef_err <= 1'b0;
            for (int k = 0; k <= ORDER; k++) begin
                // NOTE: the coefficient file is reset, not left uninitialised: reset must restore the default polynomial.
                coef[k] <= default_coef(k);
                acc[k]  <= '0;
            end
            for (int k = 0; k < ORDER; k++) xs[k] <= '0;
`ifdef POLY_PIPE_SAT_EN
            sat <= '0;
`endif
        end else begin
            // A write is only safe with nothing in flight and nothing arriving
            coef_err <= coef_we & ~coef_ok;
            if (coef_ok) begin
                for (int k = 0; k <= ORDER; k++) begin
                    if (coef_addr == 4'(k)) coef[k] <= coef_wdata;
                end
            end
            if (en) begin
                vld    <= {vld[ORDER-1:0], i_valid};
                acc[0] <= coef[ORDER];
                xs[0]  <= i_x;
                for (int j = 1; j <= ORDER; j++) acc[j] <= nxt_acc[j];
                for (int j = 1; j < ORDER; j++) xs[j] <= xs[j-1];
`ifdef POLY_PIPE_SAT_EN
                sat <= {nxt_sat, 1'b0};
`endif
            end
        end
    end

endmodule

// File: tb/tb_poly_pipe_horner.sv
// Randomised and directed bench for poly_pipe_horner, scored against a plain-arithmetic Horner model.
module tb_poly_pipe_horner;
    localparam int WIN   = 16;
    localparam int FIN   = 14;
    localparam int WOUT  = 32;
    localparam int FOUT  = 25;
    localparam int ORDER = 5;

    logic            clk;
    logic            reset;
    logic            i_valid;
    logic            o_ready;
    logic [WIN-1:0]  i_x;
    logic            o_valid;
    logic            i_ready;
    logic [WOUT-1:0] o_y;
    logic            coef_we;
    logic [3:0]      coef_addr;
    logic [WOUT-1:0] coef_wdata;
    logic            coef_err;

    poly_pipe_horner #(
        .WIDTHIN (WIN),
        .FRAC_IN (FIN),
        .WIDTHOUT(WOUT),
        .FRAC_OUT(FOUT),
        .ORDER   (ORDER)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_x       (i_x),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_y       (o_y),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .coef_err  (coef_err)
    );

    int              n_vec;
    int              n_err;
    int              n_out;
    int              n_acc;
    logic [31:0]     coef_m [0:ORDER];
    logic [31:0]     exp_q  [$];
    logic [15:0]     x_q    [$];
    logic [31:0]     last_y;
    logic [31:0]     mon_exp;
    logic [15:0]     mon_x;
    real             err_r;
    bit              taylor_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_defaults();
        coef_m[0] = 32'h0200_0000;
        coef_m[1] = 32'h0200_0000;
        coef_m[2] = 32'h0100_0000;
        coef_m[3] = 32'd5592405;
        coef_m[4] = 32'd1398101;
        coef_m[5] = 32'd279620;
    endtask

    // Horner evaluation in 64-bit integers, wrapped (or clamped) to 32 bits after each step
    function automatic logic [31:0] model(input logic [15:0] x);
        longint unsigned a;
        bit              s;
        a = 64'(coef_m[ORDER]);
        s = 1'b0;
        for (int k = ORDER - 1; k >= 0; k--) begin
            a = ((a * 64'(x)) >> FIN) + 64'(coef_m[k]);
`ifdef POLY_PIPE_SAT_EN
            if (a > 64'hFFFF_FFFF) s = 1'b1;
`endif
            a = a & 64'hFFFF_FFFF;
        end
        return s ? 32'hFFFF_FFFF : a[31:0];
    endfunction

    function automatic real taylor(input logic [15:0] x);
        real xr, term, p;
        xr   = real'(x) / 16384.0;
        term = 1.0;
        p    = 0.0;
        for (int k = 0; k <= ORDER; k++) begin
            p    = p + term;
            term = term * xr / real'(k + 1);
        end
        return p;
    endfunction

    // Scoreboard: sampled mid-cycle, after the driver's negedge updates and before the next rising edge
    always begin
        @(negedge clk);
        #3;
        if (!reset) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", o_valid, 1'b0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_x   = x_q.pop_front();
                    check("y_model", o_y, mon_exp);
                    last_y = o_y;
                    n_out++;
                    if (taylor_on) begin
                        err_r = real'(o_y) / 33554432.0 - taylor(mon_x);
                        if (err_r < 0.0) err_r = -err_r;
                        check("taylor_err_ppm", (err_r < 0.045) ? 64'd0 : 64'(longint'(err_r * 1.0e6)), 64'd0);
                    end
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_x));
                x_q.push_back(i_x);
                n_acc++;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance with i_valid low
    task automatic send(input logic [15:0] x);
        int g;
        i_valid = 1'b1;
        i_x     = x;
        for (g = 0; g < 50; g++) begin
            #3;
            if (o_ready) break;
            @(negedge clk);
        end
        if (g >= 50) check("send_timeout", g, 0);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic coef_write(input logic [3:0] addr, input logic [31:0] data, input bit exp_err);
        coef_we    = 1'b1;
        coef_addr  = addr;
        coef_wdata = data;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_err_pulse", coef_err, exp_err);
        @(negedge clk);
        check("coef_err_clear", coef_err, 1'b0);
        if (!exp_err) coef_m[addr] = data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        n_vec = 0; n_err = 0; n_out = 0; n_acc = 0;
        reset = 1'b1; i_valid = 1'b0; i_x = '0; i_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        taylor_on = 1'b0; last_y = '0;
        set_defaults();

        @(posedge clk);
        #1;
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_y", o_y, 32'h0);
        check("rst_coef_err", coef_err, 1'b0);
        check("rst_o_ready", o_ready, 1'b1);

        // x = 0 accepted on the first edge after reset release; check latency and a0
        @(negedge clk);
        reset   = 1'b0;
        i_valid = 1'b1;
        i_x     = 16'h0000;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat     = 1;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, ORDER + 1);
        check("x0_y", o_y, 32'h0200_0000);
        @(negedge clk);
        drain();

        send(16'h4000);
        drain();
        check("x1_y", last_y, 32'h056E_EEEE);

        // Bubble with a junk operand on i_x while i_valid is low
        base = n_out;
        send(16'h1234);
        i_x = 16'd23;
        repeat (3) @(negedge clk);
        send(16'h2000);
        send(16'hC000);
        drain();
        check("bubble_count", n_out - base, 3);

        // Back-to-back burst, then a 6-cycle output stall with a further input waiting
        base = n_out;
        for (int i = 0; i < 8; i++) send(16'($urandom));
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_x     = 16'($urandom);
        check("stall_entry_valid", o_valid, 1'b1);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("stall_y", o_y, exp_q[0]);
            check("stall_valid", o_valid, 1'b1);
            check("stall_ready", o_ready, 1'b0);
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        drain();
        check("stall_count", n_out - base, 9);

        // Random traffic with random back-pressure, also scored against the real-valued polynomial
        taylor_on = 1'b1;
        base      = n_acc;
        for (int c = 0; c < 2000 && (n_acc - base) < 50; c++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            i_valid = 1'($urandom_range(0, 1));
            i_x     = 16'($urandom);
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("rand_enough", (n_acc - base) >= 50, 1'b1);
        drain();
        taylor_on = 1'b0;

        // Coefficient programming: legal idle write, then rejected writes
        coef_write(4'd1, 32'h0, 1'b0);
        send(16'h4000);
        drain();
        check("a1_zero_y", last_y, 32'h036E_EEEE);

        send(16'h3000);
        coef_write(4'd2, 32'd123, 1'b1);
        drain();
        coef_write(4'd9, 32'hDEAD_BEEF, 1'b1);
        coef_write(4'(ORDER + 1), 32'd1, 1'b1);

        coef_we    = 1'b1;
        coef_addr  = 4'd0;
        coef_wdata = 32'd5;
        i_valid    = 1'b1;
        i_x        = 16'h4000;
        @(negedge clk);
        coef_we = 1'b0;
        i_valid = 1'b0;
        check("coef_err_ivalid", coef_err, 1'b1);
        drain();
        send(16'h4000);
        drain();
        check("coef_unchanged_y", last_y, 32'h036E_EEEE);

        // Large top coefficient with the largest operand
        coef_write(4'(ORDER), 32'hFFFF_FFFF, 1'b0);
        send(16'hFFFF);
        drain();
        check("big_y_model", last_y, model(16'hFFFF));
`ifdef POLY_PIPE_SAT_EN
        check("sat_all_ones", last_y, 32'hFFFF_FFFF);
`endif

        // Reset in the middle of a stream
        for (int i = 0; i < 7; i++) send(16'($urandom));
        check("pre_rst_valid", o_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", o_valid, 1'b0);
        check("mid_rst_y", o_y, 32'h0);
        exp_q.delete();
        x_q.delete();
        set_defaults();
        @(negedge clk);
        reset = 1'b0;
        send(16'h4000);
        drain();
        check("post_rst_defaults", last_y, 32'h056E_EEEE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/poly_pipe_horner.md
Name: poly_pipe_horner

Overview:
- Parametrised successor to the fixed 5th-order exp pipeline.
- Evaluates y = a0 + a1·x + … + aN·x^N using a Horner pipeline with one multiply-add per stage.
- Order and widths are parameters. Coefficients are runtime-programmable; reset defaults are the exp Taylor coefficients 1/k!.
- Sits between an upstream producer and a downstream consumer, using the team's valid/ready handshake.

Parameters:
- WIDTHIN, 16, input width; unsigned fixed point with FRAC_IN fraction bits.
- FRAC_IN, 14, fraction bits of i_x (Q2.14 by default).
- WIDTHOUT, 32, output and coefficient width; unsigned.
- FRAC_OUT, 25, fraction bits of o_y and of the coefficients (Q7.25 by default).
- ORDER, 5, polynomial order N. Legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- i_valid  in  1  upstream presents i_x.
- o_ready  out  1  block can accept i_x this cycle.
- i_x  in  WIDTHIN  input operand.
- o_valid  out  1  o_y holds a result.
- i_ready  in  1  downstream accepts o_y this cycle.
- o_y  out  WIDTHOUT  result.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  coefficient index k, 0..ORDER.
- coef_wdata  in  WIDTHOUT  coefficient value ak, unsigned Q(WIDTHOUT−FRAC_OUT).FRAC_OUT.
- coef_err  out  1  one-cycle pulse: write rejected.

Behaviour:
- Global enable: en = i_ready | ~o_valid. o_ready = en (combinational).
- Input accepted when i_valid & o_ready.
- Pipeline has ORDER+1 register stages, each with a valid bit. All stages advance together when en=1 and all hold when en=0.
- Stage 0 captures x and acc0 = aN.
- Stage j (1..ORDER) computes acc_j = ((acc_{j−1} · x) >> FRAC_IN) + a_{N−j} and forwards x.
  - Product is full-width WIDTHOUT+WIDTHIN, then truncated (floor) by the shift.
  - Sum is truncated to WIDTHOUT bits (wrap), unless SAT_EN is defined.
- Latency: o_valid rises ORDER+1 cycles after the acceptance edge when there is no stall. Throughput is 1 result per cycle.
- A valid bit advancing into a stage is the valid bit of the previous stage, so bubbles propagate. i_x is ignored when i_valid=0.
- While o_valid & ~i_ready: o_y and o_valid are held stable, o_ready=0, and no data is lost or duplicated.
- Coefficient writes:
  - Honoured only when all valid bits are 0 and i_valid=0. The new value is visible to inputs accepted on later cycles.
  - Otherwise, or if coef_addr > ORDER, the write is dropped and coef_err pulses high for 1 cycle.
- Reset values:
  - All valid bits 0; o_valid=0; o_y=0; coef_err=0.
  - Coefficient k = round(2^FRAC_OUT / k!), computed by a constant function at elaboration.
  - For defaults: a0=0x02000000, a1=0x02000000, a2=0x01000000, a3=5592405, a4=1398101, a5=279620.
- Reset mid-operation discards in-flight data and restores default coefficients. First acceptance is possible on the first edge after reset deasserts.
- Simultaneous acceptance and output drain in the same cycle is legal; the pipe shifts.

Optional Feature:
- Macro POLY_PIPE_SAT_EN.
- Defined:
  - Each stage clamps its sum to 2^WIDTHOUT−1 on overflow, including product overflow beyond WIDTHOUT bits after the shift.
  - The clamp is sticky down the pipe: a saturated stage forces all-ones at the output.
- Undefined: plain modular truncation; no extra logic.

Test Plan:
- x=0x0000 with default coefficients → o_y=0x02000000 exactly, ORDER+1=6 cycles after acceptance.
- x=0x4000 (1.0) → o_y=0x056EEEEE (91156206). Also check 50 random inputs against the real-valued Taylor model with error < 0.045.
- Back-to-back 8 inputs, then i_ready=0 for 6 cycles with the pipe full → o_y/o_valid stable, o_ready=0; after release, all 8 results in order with none lost or duplicated.
- i_valid=0 for 3 cycles with i_x=23 mid-stream → no spurious result; sequence resumes correctly.
- Write a1=0 while the pipe is idle, then x=0x4000 → o_y=0x036EEEEE. Write attempted while busy, or with coef_addr=9 → coef_err pulses and the coefficient is unchanged.
- POLY_PIPE_SAT_EN: write a5=0xFFFFFFFF, x=0xFFFF → o_y=0xFFFFFFFF. Without the macro, o_y matches the modular reference model. Assert reset mid-stream → o_valid=0 immediately and defaults are restored.
